// File: rtl/ext_reg_mailbox.sv
// ---------------------------------------------------------------------------
// ext_reg_mailbox
//
// Register-interface responder that bridges CPU register accesses to a pair
// of ready/valid streams through two synchronous FIFOs:
//   TX FIFO : CPU pushes through TXDATA, external consumer drains tx_* stream.
//   RX FIFO : external producer fills through rx_* stream, CPU pops RXDATA.
// STATUS and CTRL registers plus a level interrupt for pending RX data.
//
// Register map (addr[4:2]):
//   0x00 TXDATA W   0x04 RXDATA R   0x08 STATUS R   0x0C CTRL RW
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   reg_req_i/reg_rsp_o  register request/response (response is same-cycle)
//   tx_data_o/valid/rdy  TX stream, first-word fall-through from TX FIFO
//   rx_data_i/valid/rdy  RX stream into RX FIFO
//   irq_o                registered level interrupt: irq_en & RX non-empty
// ---------------------------------------------------------------------------

package ext_reg_mailbox_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module ext_reg_mailbox #(
    parameter type         reg_req_t = ext_reg_mailbox_pkg::reg_req_t,
    parameter type         reg_rsp_t = ext_reg_mailbox_pkg::reg_rsp_t,
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  reg_req_t             reg_req_i,
    output reg_rsp_t             reg_rsp_o,
    output logic [DataWidth-1:0] tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [DataWidth-1:0] rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic                 irq_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_RXDATA = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;

    logic [DataWidth-1:0] tx_mem [Depth];
    logic [DataWidth-1:0] rx_mem [Depth];
    logic [AW-1:0]        tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0]        tx_count, rx_count;
    logic                 irq_en;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [2:0] reg_idx;
    logic       rd_req, wr_req;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       ctrl_wr, tx_clear, rx_clear;
    logic [31:0] status_word;

    // Address bits outside the decode window and upper strobes carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0], reg_req_i.wstrb[3:1]};

    assign tx_full  = (tx_count == CW'(Depth));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(Depth));
    assign rx_empty = (rx_count == '0);

    assign reg_idx = reg_req_i.addr[4:2];
    assign rd_req  = reg_req_i.valid & ~reg_req_i.write;
    assign wr_req  = reg_req_i.valid &  reg_req_i.write;

    // Streams
    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_mem[tx_rptr];
    assign rx_ready_o = ~rx_full & ~rst_i;

    // FIFO operations. A full TX FIFO rejects the push even when the stream
    // pops in the same cycle; an empty RX FIFO fails the pop even when the
    // stream pushes in the same cycle.
    assign tx_push = wr_req & (reg_idx == OFF_TXDATA) & ~tx_full;
    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign rx_push = rx_valid_i & rx_ready_o;
    assign rx_pop  = rd_req & (reg_idx == OFF_RXDATA) & ~rx_empty;

    assign ctrl_wr  = wr_req & (reg_idx == OFF_CTRL) & reg_req_i.wstrb[0];
    assign tx_clear = ctrl_wr & reg_req_i.wdata[1];
    assign rx_clear = ctrl_wr & reg_req_i.wdata[2];

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        status_word           = '0;
        status_word[0]        = tx_full;
        status_word[1]        = tx_empty;
        status_word[2]        = rx_full;
        status_word[3]        = rx_empty;
        status_word[8 +: CW]  = tx_count;
        status_word[16 +: CW] = rx_count;
    end

    // Response is purely combinational from current state; ready is always 1.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        if (reg_req_i.valid) begin
            unique case (reg_idx)
                OFF_TXDATA: reg_rsp_o.error = reg_req_i.write & tx_full;
                OFF_RXDATA: begin
                    if (!reg_req_i.write) begin
                        reg_rsp_o.rdata = rx_empty ? '0 : rx_mem[rx_rptr];
                        reg_rsp_o.error = rx_empty;
                    end
                end
                OFF_STATUS: begin
                    if (!reg_req_i.write) reg_rsp_o.rdata = status_word;
                end
                OFF_CTRL: begin
                    if (!reg_req_i.write) reg_rsp_o.rdata = {31'b0, irq_en};
                end
                default: reg_rsp_o.error = 1'b1;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; pointers and counts alone define validity.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr] <= reg_req_i.wdata;
        if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            irq_en   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            // A clear wins over any same-cycle push or pop on that FIFO.
            if (tx_clear) begin
                tx_wptr  <= '0;
                tx_rptr  <= '0;
                tx_count <= '0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + AW'(1);
                if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
                tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            end

            if (rx_clear) begin
                rx_wptr  <= '0;
                rx_rptr  <= '0;
                rx_count <= '0;
            end else begin
                if (rx_push) rx_wptr <= rx_wptr + AW'(1);
                if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
                rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            end

            if (ctrl_wr) irq_en <= reg_req_i.wdata[0];

            // Built from pre-edge state, so irq_o trails the RX level by one cycle.
            irq_o <= irq_en & ~rx_empty;
        end
    end

endmodule
